// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Purpose  : round-robin owner of the VGA pixel-write port with grant watchdog
// Revision : 1.0
// ============================================================================
module vga_plot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [9*NUM_REQ-1:0] x_in,
    input  logic [8*NUM_REQ-1:0] y_in,
    input  logic [3*NUM_REQ-1:0] colour_in,
    input  logic [NUM_REQ-1:0]   plot_in,
    input  logic [NUM_REQ-1:0]   done_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic [8:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 timeout,
    output logic [1:0]           timeout_id
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_GRANT   = 2'd1;
    localparam logic [1:0]  S_RELEASE = 2'd2;
    localparam logic [15:0] C_LAST    = 16'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [8:0]         vx_q, vx_d;
    logic [7:0]         vy_q, vy_d;
    logic [2:0]         vc_q, vc_d;
    logic               vplot_q, vplot_d;
    logic               tmo_q, tmo_d;
    logic [1:0]         tid_q, tid_d;

    logic               w_found;
    logic [1:0]         w_win;
    logic [2:0]         w_pos;
    logic [8:0]         w_sel_x;
    logic [7:0]         w_sel_y;
    logic [2:0]         w_sel_c;
    logic               w_sel_plot;
    logic               w_sel_done;

    // First requesting index at or above ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_pos   = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, ptr_q} + 3'(k);
            if (w_pos >= 3'(NUM_REQ)) begin
                w_pos = w_pos - 3'(NUM_REQ);
            end
            if (!w_found && req[w_pos[1:0]]) begin
                w_found = 1'b1;
                w_win   = w_pos[1:0];
            end
        end
    end

    always_comb begin
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_c    = '0;
        w_sel_plot = 1'b0;
        w_sel_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_q == 2'(i)) begin
                w_sel_x    = x_in[9*i +: 9];
                w_sel_y    = y_in[8*i +: 8];
                w_sel_c    = colour_in[3*i +: 3];
                w_sel_plot = plot_in[i];
                w_sel_done = done_in[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        vplot_d = 1'b0;
        tmo_d   = 1'b0;
        tid_d   = tid_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d        = '0;
                    grant_d[w_win] = 1'b1;
                    idx_d          = w_win;
                    cnt_d          = '0;
                    state_d        = S_GRANT;
                end
            end
            S_GRANT: begin
                vx_d    = w_sel_x;
                vy_d    = w_sel_y;
                vc_d    = w_sel_c;
                vplot_d = w_sel_plot;
                cnt_d   = cnt_q + 16'd1;
                // done takes priority over an expiry in the same cycle
                if (w_sel_done || cnt_q == C_LAST) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    ptr_d   = (idx_q == 2'(NUM_REQ - 1)) ? 2'd0 : idx_q + 2'd1;
                    if (!w_sel_done) begin
                        tmo_d = 1'b1;
                        tid_d = idx_q;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            vplot_q <= 1'b0;
            tmo_q   <= 1'b0;
            tid_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            vplot_q <= vplot_d;
            tmo_q   <= tmo_d;
            tid_q   <= tid_d;
        end
    end

    assign grant      = grant_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = vplot_q;
    assign busy       = (state_q != S_IDLE);
    assign timeout    = tmo_q;
    assign timeout_id = tid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// Bench for vga_plot_arbiter: directed phases plus random traffic against a
// per-edge ownership model (owner, cycles held, release gap, rotation pointer).
module tb_vga_plot_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [9*N-1:0] x_in;
    logic [8*N-1:0] y_in;
    logic [3*N-1:0] colour_in;
    logic [N-1:0]   plot_in;
    logic [N-1:0]   done_in;
    logic [N-1:0]   grant;
    logic [8:0]     vga_x;
    logic [7:0]     vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;
    logic           busy;
    logic           timeout;
    logic [1:0]     timeout_id;

    vga_plot_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .plot_in(plot_in), .done_in(done_in),
        .grant(grant), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .timeout(timeout), .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         m_owner;
    int         m_held;
    int         m_ptr;
    bit         m_rel;
    logic [8:0] e_x;
    logic [7:0] e_y;
    logic [2:0] e_c;
    logic       e_plot;
    logic       e_tmo;
    logic [1:0] e_tid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_ptr = 0; m_rel = 0;
        e_x = '0; e_y = '0; e_c = '0; e_plot = 0; e_tmo = 0; e_tid = '0;
    endtask

    task automatic model_edge();
        bit found;
        e_tmo = 0;
        if (m_owner >= 0) begin
            e_x    = x_in[9*m_owner +: 9];
            e_y    = y_in[8*m_owner +: 8];
            e_c    = colour_in[3*m_owner +: 3];
            e_plot = plot_in[m_owner];
            m_held++;
            if (done_in[m_owner] || m_held == TMO) begin
                if (!done_in[m_owner]) begin
                    e_tmo = 1;
                    e_tid = 2'(m_owner);
                end
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_rel   = 1;
            end
        end else if (m_rel) begin
            e_plot = 0;
            m_rel  = 0;
        end else begin
            e_plot = 0;
            found  = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        chk("vga_x", 32'(vga_x), 32'(e_x));
        chk("vga_y", 32'(vga_y), 32'(e_y));
        chk("vga_colour", 32'(vga_colour), 32'(e_c));
        chk("vga_plot", 32'(vga_plot), 32'(e_plot));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || m_rel));
        chk("timeout", 32'(timeout), 32'(e_tmo));
        chk("timeout_id", 32'(timeout_id), 32'(e_tid));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_data();
        x_in      = 36'({$urandom, $urandom});
        y_in      = $urandom;
        colour_in = 12'($urandom);
        plot_in   = 4'($urandom);
    endtask

    task automatic go_idle();
        req = '0; done_in = '0;
        for (int i = 0; i < 40 && (m_owner >= 0 || m_rel); i++) begin
            done_in = '1;
            step();
        end
        done_in = '0;
    endtask

    initial begin
        resetn = 0; req = '0; x_in = '0; y_in = '0; colour_in = '0;
        plot_in = '0; done_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        resetn = 1;

        // single requester, 12 pixels then done
        req = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            done_in = (m_owner == 0 && m_held == 11) ? 4'b0001 : 4'b0000;
            step();
        end
        go_idle();

        // contention: every owner finishes after 10 pixels
        for (int i = 0; i < 70; i++) begin
            req = 4'b1111;
            rand_data();
            done_in = (m_owner >= 0 && m_held == 9) ? 4'b1111 : 4'b0000;
            step();
        end
        go_idle();

        // isolation: others show x=300 while requester 0 owns the port
        for (int i = 0; i < 14; i++) begin
            req = 4'b0001;
            rand_data();
            for (int r = 1; r < N; r++) x_in[9*r +: 9] = 9'd300;
            plot_in[2] = i[0];
            done_in = (m_owner == 0 && m_held == 12) ? 4'b0001 : 4'b0000;
            step();
        end
        go_idle();

        // watchdog: requester 1 never signals done
        for (int i = 0; i < 22; i++) begin
            req = (i < 2) ? 4'b0010 : 4'b0000;
            rand_data();
            step();
        end

        // done on the expiry cycle: normal release
        for (int i = 0; i < 22; i++) begin
            req = (i < 2) ? 4'b1000 : 4'b0000;
            rand_data();
            done_in = (m_owner >= 0 && m_held == TMO - 1) ? 4'b1111 : 4'b0000;
            step();
        end
        go_idle();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            req = 4'($urandom);
            rand_data();
            for (int r = 0; r < N; r++) done_in[r] = ($urandom_range(0, 9) == 0);
            step();
        end

        // asynchronous reset in the middle of a grant
        for (int i = 0; i < 6; i++) begin
            req = 4'b1111; rand_data(); done_in = '0;
            plot_in = '1;
            step();
        end
        #3;
        resetn = 0;
        #1;
        model_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1;
        req = 4'b0100; plot_in = '0;
        step();
        chk("post_rst_grant", 32'(grant), 32'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
